// File: rtl/ahb_decoder_dp_resp.sv
`default_nettype none
// ============================================================================
// Module   : ahb_decoder_dp_resp
// Purpose  : Per-master AHB address decoder with an inclusive-range address
//            map, lowest-index priority and optional remap of one slave
//            region. Registers the data-phase select, muxes the slave
//            hreadyout/hresp back to the master and embeds a default slave
//            that returns the two-cycle ERROR response for unmapped transfers.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_decoder_dp_resp #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 3,
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_LOW  =
    {32'h0000_2404, 32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_HIGH =
    {32'h0000_24FF, 32'h0000_100F, 32'h0000_03FF},
  parameter int REMAP_EN       = 1,
  parameter int REMAP_IDX      = 0,
  parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_LOW  = 32'h0000_8000,
  parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_HIGH = 32'h0000_83FF,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  input  logic                      err_clr,
  input  logic [SLAVE_NUM-1:0]      slv_hreadyout,
  input  logic [SLAVE_NUM-1:0]      slv_hresp,
  output logic [SLAVE_NUM-1:0]      hsel,
  output logic [SLAVE_NUM:0]        dp_sel,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [1:0] c_htrans_idle = 2'b00;
  localparam logic [ERR_CNT_WIDTH-1:0] c_cnt_one = ERR_CNT_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] c_cnt_max = {ERR_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [SLAVE_NUM-1:0]     w_hit;
  logic [SLAVE_NUM-1:0]     w_onehot;
  logic                     w_found;
  logic                     w_active;
  logic                     w_def_sel;
  logic                     w_err_start;
  logic                     w_ds_ready;
  logic                     w_ds_resp;
  logic                     w_err_entry;
  ds_state_t                r_ds_state;
  ds_state_t                w_ds_next;
  logic [SLAVE_NUM:0]       r_dp_sel;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // Per-slot inclusive range compare; the remap slot swaps in its alternate window
  generate
    for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_slot
      localparam bit c_remap_slot = (i == REMAP_IDX) && (REMAP_EN != 0);
      logic [AHB_ADDR_WIDTH-1:0] w_lo;
      logic [AHB_ADDR_WIDTH-1:0] w_hi;
      assign w_lo     = (c_remap_slot && hremap) ? REMAP_LOW
                                                 : SLV_LOW[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
      assign w_hi     = (c_remap_slot && hremap) ? REMAP_HIGH
                                                 : SLV_HIGH[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
      assign w_hit[i] = (haddr >= w_lo) && (haddr <= w_hi);
    end
  endgenerate

  // Lowest-index hit wins so the select is always one-hot or zero
  always_comb begin
    w_onehot = '0;
    w_found  = 1'b0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (w_hit[i] && !w_found) begin
        w_onehot[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign w_active    = (htrans != c_htrans_idle);
  assign hsel        = w_active ? w_onehot : '0;
  assign w_def_sel   = w_active && !(|w_hit);
  // Only NONSEQ/SEQ (htrans[1]=1) to an unmapped address earns an ERROR
  assign w_err_start = hready && w_def_sel && htrans[1];

  // Data-phase select follows the address phase only when it is accepted
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_dp_sel <= '0;
    end else if (hready) begin
      r_dp_sel <= {w_def_sel, hsel};
    end
  end

  // Default-slave state register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_ds_state <= DS_IDLE;
    end else begin
      r_ds_state <= w_ds_next;
    end
  end

  // Default-slave next state and its ready/response outputs
  always_comb begin
    w_ds_next  = r_ds_state;
    w_ds_ready = 1'b1;
    w_ds_resp  = 1'b0;
    case (r_ds_state)
      DS_IDLE: begin
        if (w_err_start) w_ds_next = DS_ERR1;
      end
      DS_ERR1: begin
        w_ds_ready = 1'b0;
        w_ds_resp  = 1'b1;
        w_ds_next  = DS_ERR2;
      end
      DS_ERR2: begin
        w_ds_resp  = 1'b1;
        w_ds_next  = w_err_start ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        w_ds_next  = DS_IDLE;
      end
    endcase
  end

  assign w_err_entry = (w_ds_next == DS_ERR1) && (r_ds_state != DS_ERR1);

  // Saturating decode-error counter; a clear beats a coincident increment
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_err_entry && (r_err_cnt != c_cnt_max)) begin
      r_err_cnt <= r_err_cnt + c_cnt_one;
    end
  end

  // Response mux driven by the registered data-phase select
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    if (r_dp_sel[SLAVE_NUM]) begin
      hreadyout = w_ds_ready;
      hresp     = w_ds_resp;
    end else begin
      for (int i = 0; i < SLAVE_NUM; i++) begin
        if (r_dp_sel[i]) begin
          hreadyout = slv_hreadyout[i];
          hresp     = slv_hresp[i];
        end
      end
    end
  end

  assign dp_sel  = r_dp_sel;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder_dp_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_decoder_dp_resp
// Purpose  : Directed self-checking bench for ahb_decoder_dp_resp; a second
//            instance with a 2-bit error counter shares all stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_decoder_dp_resp;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hremap;
  logic        err_clr;
  logic [2:0]  slv_hreadyout;
  logic [2:0]  slv_hresp;
  logic [2:0]  hsel,   hsel2;
  logic [3:0]  dp_sel, dp_sel2;
  logic        hreadyout, hreadyout2;
  logic        hresp,  hresp2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10;

  always #5 hclk = ~hclk;

  ahb_decoder_dp_resp u_dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
    .hready(hready), .hremap(hremap), .err_clr(err_clr),
    .slv_hreadyout(slv_hreadyout), .slv_hresp(slv_hresp),
    .hsel(hsel), .dp_sel(dp_sel), .hreadyout(hreadyout), .hresp(hresp),
    .err_cnt(err_cnt)
  );

  ahb_decoder_dp_resp #(.ERR_CNT_WIDTH(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
    .hready(hready), .hremap(hremap), .err_clr(err_clr),
    .slv_hreadyout(slv_hreadyout), .slv_hresp(slv_hresp),
    .hsel(hsel2), .dp_sel(dp_sel2), .hreadyout(hreadyout2), .hresp(hresp2),
    .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
    haddr  = a;
    htrans = t;
    hready = r;
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic r, input logic p);
    chk({tag, "_ready"}, hreadyout, r);
    chk({tag, "_resp"},  hresp,     p);
  endtask

  initial begin
    hreset = 1'b1; haddr = '0; htrans = IDLE; hready = 1'b1; hremap = 1'b0;
    err_clr = 1'b0; slv_hreadyout = 3'b111; slv_hresp = 3'b000;
    tick(); tick();
    chk("rst_dp_sel", dp_sel, 4'b0000);
    chk_rr("rst", 1'b1, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    hreset = 1'b0;
    tick();

    // Boundary decode, hready low so nothing is accepted
    drive(32'h0000_03FF, NSEQ, 1'b0); chk("bnd_s0_hi",   hsel, 3'b001);
    drive(32'h0000_0400, NSEQ, 1'b0); chk("bnd_s0_out",  hsel, 3'b000);
    drive(32'h0000_24FF, NSEQ, 1'b0); chk("bnd_s2_hi",   hsel, 3'b100);
    drive(32'h0000_2500, NSEQ, 1'b0); chk("bnd_s2_out",  hsel, 3'b000);
    drive(32'h0000_1000, BUSY, 1'b0); chk("busy_hsel",   hsel, 3'b010);
    drive(32'h0000_1000, IDLE, 1'b0); chk("idle_hsel",   hsel, 3'b000);
    tick();
    chk("no_accept_dp", dp_sel, 4'b0000);

    // Mapped NONSEQ to s1 top address
    drive(32'h0000_100F, NSEQ, 1'b1);
    chk("t1_hsel", hsel, 3'b010);
    slv_hreadyout = 3'b101;
    tick();
    chk("t1_dp_sel", dp_sel, 4'b0010);
    drive(32'h0, IDLE, 1'b1);
    chk_rr("t1_wait", 1'b0, 1'b0);
    slv_hreadyout = 3'b111; slv_hresp = 3'b010; #1;
    chk_rr("t1_follow", 1'b1, 1'b1);
    slv_hresp = 3'b000;
    tick();
    chk("t1_idle_dp", dp_sel, 4'b0000);

    // Unmapped NONSEQ just below s2
    drive(32'h0000_2403, NSEQ, 1'b1);
    chk("t2_hsel", hsel, 3'b000);
    tick();
    chk("t2_dp_sel", dp_sel, 4'b1000);
    drive(32'h0, IDLE, 1'b0);
    chk_rr("t2_err1", 1'b0, 1'b1);
    chk("t2_cnt", err_cnt, 8'd1);
    tick();
    drive(32'h0, IDLE, 1'b1);
    chk_rr("t2_err2", 1'b1, 1'b1);
    tick();
    chk_rr("t2_done", 1'b1, 1'b0);

    // Three back-to-back unmapped NONSEQs
    drive(32'h0000_5000, NSEQ, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      hready = 1'b0; #1;
      chk_rr($sformatf("t3_err1_%0d", k), 1'b0, 1'b1);
      tick();
      if (k == 2) drive(32'h0, IDLE, 1'b1);
      else begin hready = 1'b1; #1; end
      chk_rr($sformatf("t3_err2_%0d", k), 1'b1, 1'b1);
    end
    tick();
    chk_rr("t3_done", 1'b1, 1'b0);
    chk("t3_cnt", err_cnt, 8'd4);
    chk("t3_cnt_sat2", err_cnt2, 2'd3);

    // Remap: slot 0 moves to 0x8000..0x83FF
    hremap = 1'b1;
    drive(32'h0000_8100, NSEQ, 1'b1);
    chk("t4_remap_hsel", hsel, 3'b001);
    tick();
    chk("t4_dp_sel", dp_sel, 4'b0001);
    drive(32'h0000_0100, NSEQ, 1'b1);
    chk("t4_old_hsel", hsel, 3'b000);
    tick();
    drive(32'h0, IDLE, 1'b0);
    chk_rr("t4_err1", 1'b0, 1'b1);
    tick();
    drive(32'h0, IDLE, 1'b1);
    chk_rr("t4_err2", 1'b1, 1'b1);
    tick();
    hremap = 1'b0;
    chk("t4_cnt", err_cnt, 8'd5);

    // Hold of data-phase select while hready is low
    drive(32'h0000_0010, NSEQ, 1'b1);
    tick();
    slv_hreadyout = 3'b110;
    drive(32'h0000_1000, NSEQ, 1'b0);
    chk("t5_hsel_new", hsel, 3'b010);
    chk("t5_ready0", hreadyout, 1'b0);
    tick();
    chk("t5_hold1", dp_sel, 4'b0001);
    tick();
    chk("t5_hold2", dp_sel, 4'b0001);
    slv_hreadyout = 3'b111; hready = 1'b1; #1;
    chk("t5_ready1", hreadyout, 1'b1);
    tick();
    chk("t5_dp_new", dp_sel, 4'b0010);
    drive(32'h0, IDLE, 1'b1);
    tick();

    // BUSY to unmapped: default selected, OKAY, no count
    drive(32'h0000_5000, BUSY, 1'b1);
    tick();
    chk("busy_dp", dp_sel, 4'b1000);
    chk_rr("busy", 1'b1, 1'b0);
    chk("busy_cnt", err_cnt, 8'd5);
    drive(32'h0, IDLE, 1'b1);
    tick();

    // err_clr coincident with an error entry
    drive(32'h0000_5000, NSEQ, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", err_cnt, 8'd0);
    chk("clr_cnt2", err_cnt2, 2'd0);
    drive(32'h0, IDLE, 1'b0);
    tick();
    hready = 1'b1;
    tick();

    // Reset asserted in the middle of the ERROR response
    drive(32'h0000_5000, NSEQ, 1'b1);
    tick();
    drive(32'h0, IDLE, 1'b0);
    chk("prerst_cnt", err_cnt, 8'd1);
    chk_rr("prerst", 1'b0, 1'b1);
    hreset = 1'b1; #1;
    chk_rr("midrst", 1'b1, 1'b0);
    chk("midrst_cnt", err_cnt, 8'd0);
    chk("midrst_dp", dp_sel, 4'b0000);
    #2 hreset = 1'b0;
    hready = 1'b1;
    tick();
    chk_rr("postrst", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute timeout guard
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
